// File: rtl/rr_arbiter_8x3_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Arbiter FSM: IDLE picks a winner, GRANT holds it until release or timeout.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_arbiter_8x3_if.sv
// Request/grant bundle between the requesters and the arbiter.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the resource. It owns the resource while gnt[i] is high. It gives the
// resource back by dropping req[i]. The arbiter may take the grant away early
// with a timeout. In that case it pulses preempt for one cycle, and the
// requester must treat the resource as lost.
interface rr_arbiter_8x3_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;
  arb_state_e       state_dbg;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, preempt, state_dbg
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, preempt, state_dbg
  );

endinterface : rr_arbiter_8x3_if

// File: rtl/rr_arbiter_8x3_pick.sv
// Combinational round-robin pick. The search starts at ptr and wraps modulo 8.
// The request vector is rotated so that bit ptr lands at position 0. The
// lowest set bit is then found, and the pointer offset is added back.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic [N_REQ-1:0] win_onehot_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate, priority-encode (lowest bit first), then un-rotate the index.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any_o        = |req_i;
    win_idx_o    = any_o ? IDX_W'(ptr_i + off) : '0;
    win_onehot_o = any_o ? (N_REQ'(1) << win_idx_o) : '0;
  end

endmodule : rr_pick_8

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters. It produces a registered one-hot grant
// and a binary index. A requester that holds the resource too long while
// others wait is preempted by an optional timeout.
module rr_arbiter_8x3
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter_8x3_if.slave arb
);

  localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  // Last count value before a waiting competitor forces preemption. This is
  // also where the counter saturates when nobody else is waiting.
  localparam logic [HC_W-1:0] HOLD_LAST = PREEMPT_EN ? HC_W'(MAX_HOLD - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pre_q, pre_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             owner_req;
  logic             others_wait;

  rr_pick_8 u_pick (
    .req_i        (arb.req),
    .ptr_i        (ptr_q),
    .any_o        (pick_any),
    .win_idx_o    (pick_idx),
    .win_onehot_o (pick_onehot)
  );

  assign owner_req   = arb.req[idx_q];
  assign others_wait = |(arb.req & ~gnt_q);

  // Next-state logic: grant from IDLE, release or timeout from GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          idx_d   = pick_idx;
          ptr_d   = IDX_W'(pick_idx + 1'b1);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // A release takes priority over a timeout in the same cycle.
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
        end else if (PREEMPT_EN && hold_q == HOLD_LAST && others_wait) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          pre_d   = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = idx_q;
  assign arb.gnt_valid = |gnt_q;
  assign arb.preempt   = pre_q;
  assign arb.state_dbg = state_q;

endmodule : rr_arbiter_8x3

// File: tb/tb_rr_arbiter_8x3.sv
// Bench for rr_arbiter_8x3 (MAX_HOLD = 4): reset checks, a directed vector
// table, multi-cycle corner sequences and random traffic against a model.
module tb_rr_arbiter_8x3;
  import arb_pkg::*;

  localparam int MH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rr_arbiter_8x3_if bus ();

  rr_arbiter_8x3 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];   // {gnt[7:0], idx[2:0], valid, preempt}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is -1 when idle. The pointer and the hold count are plain integers.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_pre;

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] r);
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 8; i++) begin
        int c;
        c = (m_ptr + i) % 8;
        if (r[c]) begin
          m_owner = c;
          m_ptr   = (c + 1) % 8;
          m_hold  = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (MH > 0 && m_hold >= MH - 1 && (r & ~(8'd1 << m_owner)) != 8'd0) begin
      m_owner = -1;
      m_pre   = 1'b1;
    end else if (m_hold < MH - 1) begin
      m_hold++;
    end
  endfunction

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
    ix = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    return {g, ix, (m_owner >= 0), m_pre};
  endfunction

  // ---------------- driver ----------------
  // Called #1 after an edge. It applies req, steps the model, waits for the
  // next edge and then compares.
  task automatic tick(input logic [7:0] r);
    logic [12:0] e;
    bus.req = r;
    model_step(r);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("gnt",       32'(bus.gnt),       32'(e[12:5]));
      check("gnt_idx",   32'(bus.gnt_idx),   32'(e[4:2]));
      check("gnt_valid", 32'(bus.gnt_valid), 32'(e[1]));
      check("preempt",   32'(bus.preempt),   32'(e[0]));
    end
    check("onehot", 32'((bus.gnt & (bus.gnt - 8'd1)) == 8'd0), 1);
    check("idx_enc", 32'(bus.gnt_valid ? (bus.gnt == (8'd1 << bus.gnt_idx)) : (bus.gnt_idx == 3'd0)), 1);
    check("state_dbg", 32'(bus.state_dbg == GRANT), 32'(bus.gnt_valid));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},     32'(bus.gnt),       0);
    check({tag, ".idx"},     32'(bus.gnt_idx),   0);
    check({tag, ".valid"},   32'(bus.gnt_valid), 0);
    check({tag, ".preempt"}, 32'(bus.preempt),   0);
  endtask

  // Drop reset between edges, check the immediate clear, then release it.
  task automatic do_reset(input string tag, input logic [7:0] r_hold);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    bus.req = r_hold;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 8'd0;
    @(posedge clk);
    #1;
    model_reset();
    exp_q.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] cur;
    logic [7:0] m;

    tbl[0] = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};  // single request
    tbl[1] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};  // release
    tbl[2] = '{8'h40, 8'h40, 3'd6, 1'b1, 1'b0};  // grant 6
    tbl[3] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};  // ptr=7 -> 7 first
    tbl[5] = '{8'h01, 8'h00, 3'd0, 1'b0, 1'b0};  // 7 releases
    tbl[6] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};  // ptr wrapped -> 0
    tbl[7] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[8] = '{8'hFF, 8'h02, 3'd1, 1'b1, 1'b0};  // multi-hot, ptr=1
    tbl[9] = '{8'hFD, 8'h00, 3'd0, 1'b0, 1'b0};  // owner drops

    model_reset();

    // 1: asynchronous reset with all requests high, before any clock edge.
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_noclk");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset_clocked");
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 8'd0;
    @(posedge clk);
    #1;

    // 2 and 4: table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].req);
      check($sformatf("tbl[%0d].gnt", i),     32'(bus.gnt),       32'(tbl[i].gnt));
      check($sformatf("tbl[%0d].idx", i),     32'(bus.gnt_idx),   32'(tbl[i].idx));
      check($sformatf("tbl[%0d].valid", i),   32'(bus.gnt_valid), 32'(tbl[i].valid));
      check($sformatf("tbl[%0d].preempt", i), 32'(bus.preempt),   32'(tbl[i].pre));
    end

    // 3: rotation with all lines requesting. Order is 0..7 and back to 0.
    do_reset("rst_rot", 8'hFF);
    for (int k = 0; k < 9; k++) begin
      tick(8'hFF);
      check($sformatf("rot%0d.idx", k), 32'(bus.gnt_idx), 32'(k % 8));
      check($sformatf("rot%0d.valid", k), 32'(bus.gnt_valid), 1);
      tick(8'hFF);
      check($sformatf("rot%0d.hold", k), 32'(bus.gnt_idx), 32'(k % 8));
      tick(8'hFF & ~(8'd1 << (k % 8)));
      check($sformatf("rot%0d.dead", k), 32'(bus.gnt), 0);
    end
    tick(8'h00);

    // 5a: timeout with a waiting competitor.
    do_reset("rst_to", 8'h00);
    tick(8'h04);
    check("to.first", 32'(bus.gnt), 32'h04);
    for (int i = 0; i < 3; i++) begin
      tick(8'h24);
      check("to.kept", 32'(bus.gnt), 32'h04);
    end
    tick(8'h24);
    check("to.pre_pulse", 32'(bus.preempt), 1);
    check("to.pre_gnt0", 32'(bus.gnt), 0);
    tick(8'h24);
    check("to.next_gnt", 32'(bus.gnt), 32'h20);
    check("to.pre_cleared", 32'(bus.preempt), 0);
    tick(8'h00);

    // 5b: no competitor, so the grant is held indefinitely. Then one arrives
    // while the hold count is already saturated.
    do_reset("rst_sat", 8'h00);
    tick(8'h04);
    for (int i = 0; i < 10; i++) begin
      tick(8'h04);
      check("sat.gnt", 32'(bus.gnt), 32'h04);
      check("sat.preempt", 32'(bus.preempt), 0);
    end
    tick(8'h24);
    check("sat.late_pre", 32'(bus.preempt), 1);
    tick(8'h00);

    // Release and timeout coincide: release wins, no preempt.
    do_reset("rst_rel", 8'h00);
    tick(8'h04);
    for (int i = 0; i < 3; i++) tick(8'h24);
    tick(8'h20);
    check("relwin.preempt", 32'(bus.preempt), 0);
    check("relwin.gnt", 32'(bus.gnt), 0);
    tick(8'h20);
    check("relwin.next", 32'(bus.gnt_idx), 5);
    tick(8'h00);

    // 6: reset mid-grant clears at once, and the pointer restarts at 0.
    tick(8'h10);
    check("midrst.granted", 32'(bus.gnt), 32'h10);
    do_reset("midrst", 8'h10);
    tick(8'h03);
    check("midrst.ptr0", 32'(bus.gnt_idx), 0);
    tick(8'h00);

    // Random traffic against the model.
    cur = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      m   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cur = cur ^ m;
      if ($urandom_range(0, 23) == 0) cur = 8'h00;
      tick(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter_8x3
